// File: rtl/frame_draw_scheduler_pkg.sv
// frame_draw_scheduler_pkg: shared screen geometry, FSM state encoding and draw-phase select
package frame_draw_scheduler_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOR_W  = 3;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CLR_LOAD  = 3'd1;
    localparam logic [2:0] S_CLR_RUN   = 3'd2;
    localparam logic [2:0] S_BIRD_LOAD = 3'd3;
    localparam logic [2:0] S_BIRD_RUN  = 3'd4;
    localparam logic [2:0] S_PIPE_LOAD = 3'd5;
    localparam logic [2:0] S_PIPE_RUN  = 3'd6;
    localparam logic [2:0] S_UPDATE    = 3'd7;

    typedef enum logic [1:0] {PH_NONE, PH_CLR, PH_BIRD, PH_PIPE} phase_e;

    // Only RUN states own the plot port; everything else maps to PH_NONE.
    function automatic phase_e phase_of(input state_t s);
        return s == S_CLR_RUN  ? PH_CLR  :
               s == S_BIRD_RUN ? PH_BIRD :
               s == S_PIPE_RUN ? PH_PIPE : PH_NONE;
    endfunction

endpackage

// File: rtl/frame_draw_scheduler_draw_port_mux.sv
// frame_draw_scheduler_draw_port_mux: registered 3:1 pixel mux feeding the VGA plot port
module frame_draw_scheduler_draw_port_mux
    import frame_draw_scheduler_pkg::*;
(
    input  logic               clk,
    input  logic               rst_ni,
    input  phase_e             sel_i,
    input  logic [X_W-1:0]     clr_x_i,
    input  logic [Y_W-1:0]     clr_y_i,
    input  logic [COLOR_W-1:0] clr_c_i,
    input  logic [X_W-1:0]     bird_x_i,
    input  logic [Y_W-1:0]     bird_y_i,
    input  logic [COLOR_W-1:0] bird_c_i,
    input  logic [X_W-1:0]     pipe_x_i,
    input  logic [Y_W-1:0]     pipe_y_i,
    input  logic [COLOR_W-1:0] pipe_c_i,
    output logic [X_W-1:0]     x_o,
    output logic [Y_W-1:0]     y_o,
    output logic [COLOR_W-1:0] c_o,
    output logic               plot_o
);

    logic [X_W-1:0]     x_d, x_q;
    logic [Y_W-1:0]     y_d, y_q;
    logic [COLOR_W-1:0] c_d, c_q;
    logic               plot_q;

    // Pick the active engine's pixel; clear engine is the fallback path.
    always_comb begin
        x_d = sel_i == PH_BIRD ? bird_x_i : sel_i == PH_PIPE ? pipe_x_i : clr_x_i;
        y_d = sel_i == PH_BIRD ? bird_y_i : sel_i == PH_PIPE ? pipe_y_i : clr_y_i;
        c_d = sel_i == PH_BIRD ? bird_c_i : sel_i == PH_PIPE ? pipe_c_i : clr_c_i;
    end

    // Capture the pixel while a phase is selected; coordinates hold otherwise.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q    <= '0;
            y_q    <= '0;
            c_q    <= '0;
            plot_q <= 1'b0;
        end else begin
            plot_q <= sel_i != PH_NONE;
            if (sel_i != PH_NONE) begin
                x_q <= x_d;
                y_q <= y_d;
                c_q <= c_d;
            end
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign c_o    = c_q;
    assign plot_o = plot_q;

endmodule

// File: rtl/frame_draw_scheduler.sv
// frame_draw_scheduler: per-frame sequencer of clear/bird/pipe engines onto one VGA plot port
module frame_draw_scheduler
    import frame_draw_scheduler_pkg::*;
#(
    parameter logic [COLOR_W-1:0] BG_COLOR       = 3'b000,
    parameter logic [15:0]        TIMEOUT_CYCLES = 16'd24000
) (
    input  logic               clk,
    input  logic               resetLow,
    input  logic               frameTick,
    input  logic [1:0]         drawEnable,
    output logic               clearLoad,
    output logic [COLOR_W-1:0] clearColor,
    input  logic [X_W-1:0]     clearX,
    input  logic [Y_W-1:0]     clearY,
    input  logic [COLOR_W-1:0] clearPix,
    input  logic               clearDone,
    output logic               birdLoad,
    input  logic [X_W-1:0]     birdX,
    input  logic [Y_W-1:0]     birdY,
    input  logic [COLOR_W-1:0] birdPix,
    input  logic               birdDone,
    output logic               pipeLoad,
    input  logic [X_W-1:0]     pipeX,
    input  logic [Y_W-1:0]     pipeY,
    input  logic [COLOR_W-1:0] pipePix,
    input  logic               pipeDone,
    output logic [X_W-1:0]     vgaX,
    output logic [Y_W-1:0]     vgaY,
    output logic [COLOR_W-1:0] vgaColor,
    output logic               vgaPlot,
    output logic               gameUpdate,
    output logic               busy,
    output logic               frameOverrun,
    output logic               phaseTimeout
);

    state_t      state_q, state_d, next_phase;
    phase_e      ph;
    logic [15:0] wd_q, wd_d;
    logic        done_sel, wd_exp, run;
    logic        clr_ld_q, bird_ld_q, pipe_ld_q, upd_q, ovr_q, tmo_q;

    // Decode the running phase, its done flag, the watchdog limit and the phase that follows.
    always_comb begin
        ph         = phase_of(state_q);
        run        = ph != PH_NONE;
        done_sel   = ph == PH_CLR ? clearDone : ph == PH_BIRD ? birdDone : ph == PH_PIPE && pipeDone;
        wd_exp     = wd_q >= TIMEOUT_CYCLES - 16'd1;
        next_phase = ph == PH_CLR  ? (drawEnable[0] ? S_BIRD_LOAD : drawEnable[1] ? S_PIPE_LOAD : S_UPDATE) :
                     ph == PH_BIRD ? (drawEnable[1] ? S_PIPE_LOAD : S_UPDATE) : S_UPDATE;
        wd_d       = run ? (wd_q == 16'hFFFF ? wd_q : wd_q + 16'd1) : 16'd0;
    end

    // Next-state logic; the default arm covers the three RUN states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = frameTick ? S_CLR_LOAD : S_IDLE;
            S_CLR_LOAD:  state_d = S_CLR_RUN;
            S_BIRD_LOAD: state_d = S_BIRD_RUN;
            S_PIPE_LOAD: state_d = S_PIPE_RUN;
            S_UPDATE:    state_d = S_IDLE;
            default:     state_d = (done_sel || wd_exp) ? next_phase : state_q;
        endcase
    end

    // State, watchdog, next-state-decoded strobes and sticky error flags.
    always_ff @(posedge clk or negedge resetLow) begin
        if (!resetLow) begin
            state_q   <= S_IDLE;
            wd_q      <= '0;
            clr_ld_q  <= 1'b0;
            bird_ld_q <= 1'b0;
            pipe_ld_q <= 1'b0;
            upd_q     <= 1'b0;
            ovr_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            clr_ld_q  <= state_d == S_CLR_LOAD;
            bird_ld_q <= state_d == S_BIRD_LOAD;
            pipe_ld_q <= state_d == S_PIPE_LOAD;
            upd_q     <= state_d == S_UPDATE;
            ovr_q     <= ovr_q | (frameTick && state_q != S_IDLE);
            tmo_q     <= tmo_q | (run && !done_sel && wd_exp);
        end
    end

    frame_draw_scheduler_draw_port_mux u_mux (
        .clk      (clk),
        .rst_ni   (resetLow),
        .sel_i    (phase_of(state_d)),
        .clr_x_i  (clearX),
        .clr_y_i  (clearY),
        .clr_c_i  (clearPix),
        .bird_x_i (birdX),
        .bird_y_i (birdY),
        .bird_c_i (birdPix),
        .pipe_x_i (pipeX),
        .pipe_y_i (pipeY),
        .pipe_c_i (pipePix),
        .x_o      (vgaX),
        .y_o      (vgaY),
        .c_o      (vgaColor),
        .plot_o   (vgaPlot)
    );

    assign clearLoad    = clr_ld_q;
    assign birdLoad     = bird_ld_q;
    assign pipeLoad     = pipe_ld_q;
    assign gameUpdate   = upd_q;
    assign frameOverrun = ovr_q;
    assign phaseTimeout = tmo_q;
    assign busy         = state_q != S_IDLE;
    assign clearColor   = BG_COLOR;

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb_frame_draw_scheduler: engine models plus a pixel scoreboard around frame_draw_scheduler
module tb_frame_draw_scheduler;

    localparam int TMO   = 24000;
    localparam int NEVER = 1 << 30;

    logic       clk = 1'b0;
    logic       resetLow, frameTick, fp, stale_req;
    logic [1:0] drawEnable;
    logic       clearLoad, birdLoad, pipeLoad, clearDone, birdDone, pipeDone;
    logic [2:0] clearColor, clearPix, birdPix, pipePix, vgaColor;
    logic [7:0] clearX, birdX, pipeX, vgaX;
    logic [6:0] clearY, birdY, pipeY, vgaY;
    logic       vgaPlot, gameUpdate, busy, frameOverrun, phaseTimeout;

    int         n[3];
    int         cnt[3];
    logic [2:0] act = '0, stale = '0, done, ld;
    int         cyc = 0;

    int checks = 0, errors = 0;
    int n_clr = 0, n_bird = 0, n_pipe = 0, n_upd = 0, plot_n = 0;
    int t_clr = 0, t_bird = 0, t_pipe = 0, t_upd = 0;
    int b_clr, b_bird, b_pipe, b_upd, b_plot;
    logic [17:0] sb[$];
    logic [17:0] exp_pix;
    int          cur = 0, rc = 0;
    logic        drawing = 1'b0;

    always #5 clk = ~clk;

    frame_draw_scheduler dut (
        .clk(clk), .resetLow(resetLow), .frameTick(frameTick), .drawEnable(drawEnable),
        .clearLoad(clearLoad), .clearColor(clearColor), .clearX(clearX), .clearY(clearY),
        .clearPix(clearPix), .clearDone(clearDone),
        .birdLoad(birdLoad), .birdX(birdX), .birdY(birdY), .birdPix(birdPix), .birdDone(birdDone),
        .pipeLoad(pipeLoad), .pipeX(pipeX), .pipeY(pipeY), .pipePix(pipePix), .pipeDone(pipeDone),
        .vgaX(vgaX), .vgaY(vgaY), .vgaColor(vgaColor), .vgaPlot(vgaPlot),
        .gameUpdate(gameUpdate), .busy(busy), .frameOverrun(frameOverrun), .phaseTimeout(phaseTimeout)
    );

    assign ld       = {pipeLoad, birdLoad, clearLoad};
    assign clearX   = fp ? 8'd37 : 8'(cyc % 160);
    assign clearY   = fp ? 7'd100 : 7'(cyc % 120);
    assign clearPix = fp ? 3'b101 : 3'(cyc);
    assign birdX    = 8'((cyc + 50) % 160);
    assign birdY    = 7'((cyc + 7) % 120);
    assign birdPix  = 3'(cyc + 3);
    assign pipeX    = 8'((cyc + 100) % 160);
    assign pipeY    = 7'((cyc + 60) % 120);
    assign pipePix  = 3'(cyc ^ 5);
    assign clearDone = done[0];
    assign birdDone  = done[1];
    assign pipeDone  = done[2];

    always_comb
        for (int e = 0; e < 3; e++) done[e] = stale[e] | (act[e] & (cnt[e] >= n[e] - 1));

    // Engine models: load restarts the count and drops any stale done.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int e = 0; e < 3; e++)
            if (ld[e]) begin
                act[e]   <= 1'b1;
                cnt[e]   <= 0;
                stale[e] <= 1'b0;
            end else begin
                if (act[e]) cnt[e] <= cnt[e] + 1;
                if (stale_req && e == 0) stale[e] <= 1'b1;
            end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] epix(input int e);
        return e == 0 ? {clearX, clearY, clearPix} : e == 1 ? {birdX, birdY, birdPix} : {pipeX, pipeY, pipePix};
    endfunction

    // Scoreboard: each engine pixel the DUT should capture is queued, each plotted pixel pops one.
    always @(negedge clk) begin
        if (!resetLow) begin
            sb.delete();
            drawing = 1'b0;
        end else begin
            if (vgaPlot) begin
                plot_n++;
                if (sb.size() == 0) check("sb_underflow", 1, 0);
                else begin
                    exp_pix = sb.pop_front();
                    check("pixel", {14'd0, vgaX, vgaY, vgaColor}, {14'd0, exp_pix});
                end
            end
            if (clearLoad)  begin n_clr++;  t_clr  = cyc; end
            if (birdLoad)   begin n_bird++; t_bird = cyc; end
            if (pipeLoad)   begin n_pipe++; t_pipe = cyc; end
            if (gameUpdate) begin n_upd++;  t_upd  = cyc; end
            if (|ld) begin
                cur = clearLoad ? 0 : birdLoad ? 1 : 2;
                drawing = 1'b1;
                rc = 0;
                sb.push_back(epix(cur));
            end else if (drawing) begin
                rc++;
                if (done[cur] || rc == TMO) drawing = 1'b0;
                else sb.push_back(epix(cur));
            end
        end
    end

    task automatic snap;
        b_clr = n_clr; b_bird = n_bird; b_pipe = n_pipe; b_upd = n_upd; b_plot = plot_n;
    endtask

    task automatic wait_idle;
        int k = 0;
        while (busy && k < 60000) begin
            @(negedge clk);
            k++;
        end
        check("frame_end", {31'd0, busy}, 0);
        @(negedge clk);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic run_frame;
        @(negedge clk) frameTick = 1'b1;
        @(negedge clk) frameTick = 1'b0;
        wait_idle();
    endtask

    initial begin
        int k;
        resetLow = 1'b0; frameTick = 1'b0; drawEnable = 2'b00; fp = 1'b0; stale_req = 1'b0;
        n[0] = 19320; n[1] = 40; n[2] = 200;
        repeat (3) @(negedge clk);
        check("rst_plot", vgaPlot, 0);
        check("rst_busy", busy, 0);
        check("rst_clrld", clearLoad, 0);
        check("rst_upd", gameUpdate, 0);
        check("rst_ovr", frameOverrun, 0);
        check("rst_tmo", phaseTimeout, 0);
        check("rst_color", clearColor, 0);
        check("rst_vgax", vgaX, 0);
        @(negedge clk) resetLow = 1'b1;

        snap(); drawEnable = 2'b11;
        run_frame();
        check("t1_clr_ld", n_clr - b_clr, 1);
        check("t1_bird_ld", n_bird - b_bird, 1);
        check("t1_pipe_ld", n_pipe - b_pipe, 1);
        check("t1_upd", n_upd - b_upd, 1);
        check("t1_plot", plot_n - b_plot, 19560);
        check("t1_bird_at", t_bird - t_clr, 19321);
        check("t1_pipe_at", t_pipe - t_bird, 41);
        check("t1_upd_at", t_upd - t_pipe, 201);
        check("t1_ovr", frameOverrun, 0);

        snap(); drawEnable = 2'b00; n[0] = 50;
        run_frame();
        check("t2_bird_ld", n_bird - b_bird, 0);
        check("t2_pipe_ld", n_pipe - b_pipe, 0);
        check("t2_plot", plot_n - b_plot, 50);
        check("t2_upd_at", t_upd - t_clr, 51);

        snap(); n[0] = 100;
        @(negedge clk) stale_req = 1'b1;
        @(negedge clk) stale_req = 1'b0;
        run_frame();
        check("t3_plot", plot_n - b_plot, 100);
        check("t3_upd_at", t_upd - t_clr, 101);
        check("t3_tmo", phaseTimeout, 0);

        snap(); drawEnable = 2'b11; n[0] = 20; n[1] = NEVER; n[2] = 30;
        run_frame();
        check("t4_tmo", phaseTimeout, 1);
        check("t4_pipe_at", t_pipe - t_bird, TMO + 1);
        check("t4_pipe_ld", n_pipe - b_pipe, 1);
        check("t4_upd", n_upd - b_upd, 1);
        check("t4_plot", plot_n - b_plot, 20 + TMO + 30);

        snap(); n[0] = 20; n[1] = 10; n[2] = 30;
        @(negedge clk) frameTick = 1'b1;
        @(negedge clk) frameTick = 1'b0;
        k = 0;
        while (!pipeLoad && k < 500) begin @(negedge clk); k++; end
        check("t5_reach_pipe", pipeLoad, 1);
        repeat (5) @(negedge clk);
        frameTick = 1'b1;
        @(negedge clk) frameTick = 1'b0;
        check("t5_ovr", frameOverrun, 1);
        k = 0;
        while (!gameUpdate && k < 500) begin @(negedge clk); k++; end
        check("t5_reach_upd", gameUpdate, 1);
        frameTick = 1'b1;
        @(negedge clk) frameTick = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("t5_clr_ld", n_clr - b_clr, 1);
        check("t5_upd", n_upd - b_upd, 1);
        snap();
        run_frame();
        check("t5_next_clr", n_clr - b_clr, 1);
        check("t5_next_upd", n_upd - b_upd, 1);

        drawEnable = 2'b00; n[0] = 1000;
        @(negedge clk) frameTick = 1'b1;
        @(negedge clk) frameTick = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk) #1 fp = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6_x", vgaX, 37);
        check("t6_y", vgaY, 100);
        check("t6_c", vgaColor, 5);
        check("t6_plot", vgaPlot, 1);
        #2 fp = 1'b0; resetLow = 1'b0;
        #1;
        check("t6_rst_plot", vgaPlot, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ovr", frameOverrun, 0);
        repeat (2) @(negedge clk);
        #1 resetLow = 1'b1;
        snap(); n[0] = 50;
        run_frame();
        check("t6_after_upd", n_upd - b_upd, 1);
        check("t6_after_plot", plot_n - b_plot, 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
